// File: rtl/lc_responder_if.sv
// L1 <-> LC line interface: request channel, fill channel, preload port and out-of-range flag.
interface lc_responder_if #(
  parameter int LINE_BYTES = 64
);
  localparam int LINE_W = LINE_BYTES * 8;

  logic              req_valid_in;
  logic              req_ready_out;
  logic [63:0]       req_addr_in;
  logic              req_we_in;
  logic [LINE_W-1:0] req_value_in;
  logic              resp_valid_out;
  logic              resp_ready_in;
  logic [63:0]       resp_addr_out;
  logic [LINE_W-1:0] resp_value_out;
  logic              load_valid_in;
  logic [63:0]       load_addr_in;
  logic [LINE_W-1:0] load_value_in;
  logic              oob_out;

  modport master (
    output req_valid_in, req_addr_in, req_we_in, req_value_in, resp_ready_in,
           load_valid_in, load_addr_in, load_value_in,
    input  req_ready_out, resp_valid_out, resp_addr_out, resp_value_out, oob_out
  );

  modport slave (
    input  req_valid_in, req_addr_in, req_we_in, req_value_in, resp_ready_in,
           load_valid_in, load_addr_in, load_value_in,
    output req_ready_out, resp_valid_out, resp_addr_out, resp_value_out, oob_out
  );
endinterface

// File: rtl/lc_responder.sv
// LC-side line responder: fixed-latency reads (READ_LATENCY to fill valid) and writes (WRITE_LATENCY busy).
// One request in flight; req_ready_out drops from handshake until the fill is taken or the write commits.
module lc_responder #(
  parameter int LINE_BYTES    = 64,
  parameter int MEM_LINES     = 64,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  lc_responder_if.slave lc
);
  localparam int          LINE_W    = LINE_BYTES * 8;
  localparam int          OFF_W     = $clog2(LINE_BYTES);
  localparam int          IDX_W     = $clog2(MEM_LINES);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_LINES * LINE_BYTES);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t            state;
  logic [15:0]       cnt;
  logic [63:0]       lat_addr;
  logic [LINE_W-1:0] lat_value;
  logic              lat_inr;
  logic [LINE_W-1:0] mem [MEM_LINES];

  logic             req_fire;
  logic             req_inr;
  logic             load_hit;
  logic             commit;
  logic [IDX_W-1:0] lat_idx;
  logic [IDX_W-1:0] load_idx;

  assign req_fire = lc.req_valid_in & lc.req_ready_out;
  assign req_inr  = lc.req_addr_in < MEM_BYTES;
  assign load_hit = lc.load_valid_in & (lc.load_addr_in < MEM_BYTES);
  assign lat_idx  = lat_addr[OFF_W +: IDX_W];
  assign load_idx = lc.load_addr_in[OFF_W +: IDX_W];
  assign commit   = !rst_in && (state == WR_WAIT) && (cnt == 16'd0) && lat_inr;

  // Array is never reset; the preload write is placed last so it wins a same-line collision.
  always_ff @(posedge clk_in) begin
    if (commit)
      mem[lat_idx] <= lat_value;
    if (load_hit)
      mem[load_idx] <= lc.load_value_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      cnt               <= 16'd0;
      lat_addr          <= '0;
      lat_value         <= '0;
      lat_inr           <= 1'b0;
      lc.req_ready_out  <= 1'b0;
      lc.resp_valid_out <= 1'b0;
      lc.resp_addr_out  <= '0;
      lc.resp_value_out <= '0;
      lc.oob_out        <= 1'b0;
    end else begin
      lc.oob_out <= 1'b0;
      case (state)
        IDLE: begin
          lc.req_ready_out <= 1'b1;
          if (req_fire) begin
            lat_addr         <= {lc.req_addr_in[63:OFF_W], OFF_W'(0)};
            lat_value        <= lc.req_value_in;
            lat_inr          <= req_inr;
            lc.oob_out       <= !req_inr;
            lc.req_ready_out <= 1'b0;
            if (lc.req_we_in) begin
              state <= WR_WAIT;
              cnt   <= 16'(WRITE_LATENCY - 1);
            end else begin
              state <= RD_WAIT;
              cnt   <= 16'(READ_LATENCY - 1);
            end
          end
        end
        RD_WAIT: begin
          if (cnt == 16'd0) begin
            lc.resp_value_out <= lat_inr ? mem[lat_idx] : '0;
            lc.resp_addr_out  <= lat_addr;
            lc.resp_valid_out <= 1'b1;
            state             <= RESP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        WR_WAIT: begin
          if (cnt == 16'd0) begin
            state            <= IDLE;
            lc.req_ready_out <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RESP: begin
          if (lc.resp_ready_in) begin
            lc.resp_valid_out <= 1'b0;
            lc.req_ready_out  <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc_responder.sv
// Directed bench for lc_responder: table of read/write transactions plus hand sequences for backpressure, reset and collisions.
module tb_lc_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lc_responder_if #(.LINE_BYTES(64)) bus ();

  lc_responder #(
    .LINE_BYTES(64), .MEM_LINES(64), .READ_LATENCY(4), .WRITE_LATENCY(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .lc    (bus)
  );

  typedef struct {
    logic [63:0]  addr;
    logic         we;
    logic [511:0] wdata;
    logic [511:0] exp_val;
    logic [63:0]  exp_addr;
    logic         exp_oob;
  } vec_t;

  vec_t vecs[8];

  localparam logic [511:0] A5  = {64{8'hA5}};
  localparam logic [511:0] P1  = {16{32'h0101_1111}};
  localparam logic [511:0] P4A = {16{32'h4444_0000}};
  localparam logic [511:0] P4B = {16{32'h4444_BBBB}};
  localparam logic [511:0] P4C = {16{32'h4444_CCCC}};
  localparam logic [511:0] P63 = {16{32'h6363_6363}};
  localparam logic [511:0] LDC = {16{32'hC0C0_1D1D}};

  task automatic chkv(input string n, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  task automatic preload(input logic [63:0] a, input logic [511:0] v);
    @(negedge clk);
    bus.load_valid_in = 1'b1;
    bus.load_addr_in  = a;
    bus.load_value_in = v;
    @(negedge clk);
    bus.load_valid_in = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] a, input logic [511:0] ev,
                         input logic [63:0] ea, input logic eo);
    int k;
    @(negedge clk);
    chk1("rd_ready_before", bus.req_ready_out, 1'b1);
    bus.req_valid_in  = 1'b1;
    bus.req_addr_in   = a;
    bus.req_we_in     = 1'b0;
    bus.resp_ready_in = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    chk1("rd_oob", bus.oob_out, eo);
    k = 0;
    while (!bus.resp_valid_out && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) chk1("rd_oob_pulse_end", bus.oob_out, 1'b0);
      if (!bus.resp_valid_out) chk1("rd_ready_busy", bus.req_ready_out, 1'b0);
    end
    chkv("rd_latency", 512'(k), 512'(4));
    chkv("rd_addr", 512'(bus.resp_addr_out), 512'(ea));
    chkv("rd_value", bus.resp_value_out, ev);
    @(posedge clk); #1;
    chk1("rd_valid_drop", bus.resp_valid_out, 1'b0);
    chk1("rd_ready_back", bus.req_ready_out, 1'b1);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [511:0] d, input logic eo);
    int lowcnt;
    @(negedge clk);
    chk1("wr_ready_before", bus.req_ready_out, 1'b1);
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = a;
    bus.req_we_in    = 1'b1;
    bus.req_value_in = d;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    bus.req_we_in    = 1'b0;
    chk1("wr_oob", bus.oob_out, eo);
    lowcnt = 0;
    while (!bus.req_ready_out && lowcnt < 20) begin
      chk1("wr_no_resp", bus.resp_valid_out, 1'b0);
      lowcnt++;
      @(posedge clk); #1;
    end
    chkv("wr_busy_cycles", 512'(lowcnt), 512'(2));
    chk1("wr_no_resp_after", bus.resp_valid_out, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_in  = 1'b0;
    bus.req_addr_in   = '0;
    bus.req_we_in     = 1'b0;
    bus.req_value_in  = '0;
    bus.resp_ready_in = 1'b1;
    bus.load_valid_in = 1'b0;
    bus.load_addr_in  = '0;
    bus.load_value_in = '0;

    vecs[0] = '{64'h0,    1'b0, '0,           A5,            64'h0,    1'b0};
    vecs[1] = '{64'h47,   1'b0, '0,           P1,            64'h40,   1'b0};
    vecs[2] = '{64'h80,   1'b1, 512'hDEADBEEF, '0,           64'h0,    1'b0};
    vecs[3] = '{64'h80,   1'b0, '0,           512'hDEADBEEF, 64'h80,   1'b0};
    vecs[4] = '{64'h1000, 1'b0, '0,           '0,            64'h1000, 1'b1};
    vecs[5] = '{64'h1000, 1'b1, 512'h1234,    '0,            64'h0,    1'b1};
    vecs[6] = '{64'h0,    1'b0, '0,           A5,            64'h0,    1'b0};
    vecs[7] = '{64'hFC5,  1'b0, '0,           P63,           64'hFC0,  1'b0};

    // Reset state, including preloads issued while reset is held.
    bus.load_valid_in = 1'b1;
    bus.load_addr_in  = 64'h0;
    bus.load_value_in = A5;
    repeat (3) @(posedge clk);
    #1;
    bus.load_valid_in = 1'b0;
    chk1("rst_req_ready", bus.req_ready_out, 1'b0);
    chk1("rst_resp_valid", bus.resp_valid_out, 1'b0);
    chk1("rst_oob", bus.oob_out, 1'b0);
    chkv("rst_resp_addr", 512'(bus.resp_addr_out), '0);
    chkv("rst_resp_value", bus.resp_value_out, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("post_rst_ready", bus.req_ready_out, 1'b1);

    preload(64'h40, P1);
    preload(64'hFC0, P63);
    preload(64'h1000, {16{32'hBADBAD00}});

    foreach (vecs[i]) begin
      if (vecs[i].we)
        do_write(vecs[i].addr, vecs[i].wdata, vecs[i].exp_oob);
      else
        do_read(vecs[i].addr, vecs[i].exp_val, vecs[i].exp_addr, vecs[i].exp_oob);
    end

    // Fill held under backpressure: addr/value stable, no new request accepted.
    @(negedge clk);
    bus.req_valid_in  = 1'b1;
    bus.req_addr_in   = 64'h47;
    bus.req_we_in     = 1'b0;
    bus.resp_ready_in = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    for (int k = 0; k < 20 && !bus.resp_valid_out; k++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 10; c++) begin
      chk1("bp_valid", bus.resp_valid_out, 1'b1);
      chkv("bp_addr", 512'(bus.resp_addr_out), 512'(64'h40));
      chkv("bp_value", bus.resp_value_out, P1);
      chk1("bp_ready_low", bus.req_ready_out, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.resp_ready_in = 1'b1;
    @(posedge clk); #1;
    chk1("bp_valid_drop", bus.resp_valid_out, 1'b0);
    chk1("bp_ready_back", bus.req_ready_out, 1'b1);

    // Preload during RD_WAIT reaches the fill; preload after the sample does not.
    preload(64'h100, P4A);
    @(negedge clk);
    bus.req_valid_in  = 1'b1;
    bus.req_addr_in   = 64'h100;
    bus.resp_ready_in = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    preload(64'h100, P4B);
    for (int k = 0; k < 20 && !bus.resp_valid_out; k++) begin
      @(posedge clk); #1;
    end
    chkv("mid_preload_value", bus.resp_value_out, P4B);
    preload(64'h100, P4C);
    chkv("late_preload_hidden", bus.resp_value_out, P4B);
    bus.resp_ready_in = 1'b1;
    @(posedge clk); #1;
    do_read(64'h100, P4C, 64'h100, 1'b0);

    // Reset two cycles into RD_WAIT: request discarded, array retained.
    @(negedge clk);
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = 64'h80;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("mid_rst_ready", bus.req_ready_out, 1'b0);
    chk1("mid_rst_valid", bus.resp_valid_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk1("mid_rst_no_fill", bus.resp_valid_out, 1'b0);
      if (c == 0) chk1("mid_rst_ready_back", bus.req_ready_out, 1'b1);
    end
    do_read(64'h80, 512'hDEADBEEF, 64'h80, 1'b0);

    // Reset before a write commits: line 0 must keep its preload.
    @(negedge clk);
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = 64'h0;
    bus.req_we_in    = 1'b1;
    bus.req_value_in = 512'hBAD;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    bus.req_we_in    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(64'h0, A5, 64'h0, 1'b0);

    // Write commit and preload hit line 0xC0 on the same edge: preload wins.
    @(negedge clk);
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = 64'hC0;
    bus.req_we_in    = 1'b1;
    bus.req_value_in = 512'h5555;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    bus.req_we_in    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.load_valid_in = 1'b1;
    bus.load_addr_in  = 64'hC0;
    bus.load_value_in = LDC;
    @(posedge clk); #1;
    chk1("collide_ready_back", bus.req_ready_out, 1'b1);
    @(negedge clk);
    bus.load_valid_in = 1'b0;
    do_read(64'hC0, LDC, 64'hC0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
